// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: widths, register-zero constant,
// the decoded control bundle and ALU operation encodings.
package mips_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;
  localparam int REG_AW  = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hc
  } alu_op_e;

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use check: a load in EX whose Rt feeds
// either source specifier of the instruction in ID.
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          ex_mem_read_i,
  input  logic          ex_valid_i,
  input  logic [AW-1:0] ex_rt_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  output logic          load_use_o
);

  logic rt_nz;
  logic rt_hit;

  assign rt_nz  = (ex_rt_i != AW'(REG_ZERO));
  assign rt_hit = (ex_rt_i == id_rs_i) ||
                  (ex_rt_i == id_rt_i);

  // Conservative: Rt match counts even if ID never reads Rt.
  assign load_use_o = ex_mem_read_i && ex_valid_i &&
                      rt_nz && rt_hit;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble, flush and freeze.
// Define IDEX_STALL_STATS_EN to add stall/flush event counters.
module id_ex_pipe_reg #(
  parameter int DATA_W  = mips_pipe_pkg::DATA_W,
  parameter int ALUOP_W = mips_pipe_pkg::ALUOP_W,
  parameter int REG_AW  = mips_pipe_pkg::REG_AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ext_stall,
  input  logic               flush,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_rdata1,
  output logic [DATA_W-1:0]  ex_rdata2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_valid,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               hazard_stall
`ifdef IDEX_STALL_STATS_EN
  ,
  output logic [31:0]        stall_count,
  output logic [31:0]        flush_count
`endif
);

  import mips_pipe_pkg::ctrl_t;

  ctrl_t              id_ctrl;
  ctrl_t              ctrl_d, ctrl_q;
  logic [DATA_W-1:0]  rdata1_d, rdata1_q;
  logic [DATA_W-1:0]  rdata2_d, rdata2_q;
  logic [DATA_W-1:0]  imm_d, imm_q;
  logic [DATA_W-1:0]  pc4_d, pc4_q;
  logic [REG_AW-1:0]  rs_d, rs_q;
  logic [REG_AW-1:0]  rt_d, rt_q;
  logic [REG_AW-1:0]  rd_d, rd_q;
  logic               valid_d, valid_q;
  logic               load_use;
  logic               bubble;

  assign id_ctrl = '{
    reg_write:  id_reg_write,
    mem_to_reg: id_mem_to_reg,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    alu_src:    id_alu_src,
    reg_dst:    id_reg_dst,
    alu_op:     id_alu_op
  };

  load_use_detect #(
    .AW(REG_AW)
  ) u_lud (
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_valid_i    (valid_q),
    .ex_rt_i       (rt_q),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .load_use_o    (load_use)
  );

  // Flush outranks the hazard so the front end moves to the target.
  assign hazard_stall = load_use && !flush;
  assign pc_write     = !(ext_stall || hazard_stall);
  assign if_id_write  = !(ext_stall || hazard_stall);
  assign bubble       = flush || hazard_stall;

  always_comb begin
    ctrl_d   = ctrl_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    pc4_d    = pc4_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    if (ext_stall) begin
      valid_d = valid_q;
    end else if (bubble) begin
      ctrl_d   = '0;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      pc4_d    = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      valid_d  = 1'b0;
    end else begin
      ctrl_d   = id_ctrl;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      pc4_d    = id_pc4;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      pc4_q    <= pc4_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
    end
  end

  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_rdata1     = rdata1_q;
  assign ex_rdata2     = rdata2_q;
  assign ex_imm        = imm_q;
  assign ex_pc4        = pc4_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_valid      = valid_q;

`ifdef IDEX_STALL_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Saturating: a pegged counter means "at least this many".
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ext_stall && hazard_stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!ext_stall && flush && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios then
// randomized traffic against a rule-level reference model.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        rw, m2r, mr, mw, as, rd;
    logic [3:0]  op;
    logic [31:0] r1, r2, imm, pc4;
    logic [4:0]  rs, rt, rdd;
    logic        v;
  } ex_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ext_stall = 1'b0;
  logic flush = 1'b0;
  ex_t  inp = '0;
  ex_t  m = '0;
  ex_t  obs;
  ex_t  snap;
  logic m_known = 1'b0;
  int   total = 0;
  int   bad = 0;
  int unsigned m_sc = 0;
  int unsigned m_fc = 0;

  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read;
  logic        ex_mem_write, ex_alu_src, ex_reg_dst;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid, pc_write, if_id_write, hazard_stall;
`ifdef IDEX_STALL_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ext_stall     (ext_stall),
    .flush         (flush),
    .id_reg_write  (inp.rw),
    .id_mem_to_reg (inp.m2r),
    .id_mem_read   (inp.mr),
    .id_mem_write  (inp.mw),
    .id_alu_src    (inp.as),
    .id_reg_dst    (inp.rd),
    .id_alu_op     (inp.op),
    .id_rdata1     (inp.r1),
    .id_rdata2     (inp.r2),
    .id_imm        (inp.imm),
    .id_pc4        (inp.pc4),
    .id_rs         (inp.rs),
    .id_rt         (inp.rt),
    .id_rd         (inp.rdd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_alu_src    (ex_alu_src),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_op     (ex_alu_op),
    .ex_rdata1     (ex_rdata1),
    .ex_rdata2     (ex_rdata2),
    .ex_imm        (ex_imm),
    .ex_pc4        (ex_pc4),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_valid      (ex_valid),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .hazard_stall  (hazard_stall)
`ifdef IDEX_STALL_STATS_EN
    ,
    .stall_count   (stall_count),
    .flush_count   (flush_count)
`endif
  );

  assign obs = {ex_reg_write, ex_mem_to_reg, ex_mem_read,
                ex_mem_write, ex_alu_src, ex_reg_dst, ex_alu_op,
                ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
                ex_rs, ex_rt, ex_rd, ex_valid};

  task automatic chk(input string tag, input logic [255:0] o,
                     input logic [255:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic m_hz();
    logic lu;
    lu = m.mr && m.v && (m.rt != 5'd0) &&
         ((m.rt == inp.rs) || (m.rt == inp.rt));
    return lu && !flush;
  endfunction

  task automatic comb_chk();
    logic hz;
    @(negedge clk);
    if (m_known) begin
      hz = m_hz();
      chk("hazard_stall", 256'(hazard_stall), 256'(hz));
      chk("pc_write", 256'(pc_write), 256'(!(ext_stall || hz)));
      chk("if_id_write", 256'(if_id_write),
          256'(!(ext_stall || hz)));
    end
  endtask

  task automatic edge_upd();
    logic hz;
    @(posedge clk);
    hz = m_hz();
    if (!reset_n) begin
      m = '0;
      m_sc = 0;
      m_fc = 0;
      m_known = 1'b1;
    end else if (!ext_stall) begin
      if (hz && m_sc != 32'hffff_ffff) m_sc++;
      if (flush && m_fc != 32'hffff_ffff) m_fc++;
      if (flush || hz) begin
        m = '0;
      end else begin
        m = inp;
        m.v = 1'b1;
      end
    end
    #1;
    chk("ex_bundle", 256'(obs), 256'(m));
`ifdef IDEX_STALL_STATS_EN
    chk("stall_count", 256'(stall_count), 256'(m_sc));
    chk("flush_count", 256'(flush_count), 256'(m_fc));
`endif
  endtask

  task automatic step();
    comb_chk();
    edge_upd();
  endtask

  task automatic rand_inp();
    inp.rw  = 1'($urandom);
    inp.m2r = 1'($urandom);
    inp.mr  = 1'($urandom);
    inp.mw  = 1'($urandom);
    inp.as  = 1'($urandom);
    inp.rd  = 1'($urandom);
    inp.op  = 4'($urandom);
    inp.r1  = $urandom;
    inp.r2  = $urandom;
    inp.imm = $urandom;
    inp.pc4 = $urandom;
    inp.rs  = 5'($urandom_range(0, 3));
    inp.rt  = 5'($urandom_range(0, 3));
    inp.rdd = 5'($urandom);
    inp.v   = 1'b0;
  endtask

  initial begin
    // Reset with arbitrary ID contents.
    reset_n = 1'b0;
    rand_inp();
    step();
    rand_inp();
    step();
    chk("rst_bundle", 256'(obs), 256'(0));
    chk("rst_pc_write", 256'(pc_write), 256'(1));
    reset_n = 1'b1;

    // Normal pipeline.
    inp = '0;
    inp.op = 4'h2;
    inp.r1 = 32'h1234;
    inp.rs = 5'd5;
    inp.rt = 5'd6;
    step();
    chk("norm_op", 256'(ex_alu_op), 256'(4'h2));
    chk("norm_r1", 256'(ex_rdata1), 256'(32'h1234));
    chk("norm_rs", 256'(ex_rs), 256'(5'd5));
    chk("norm_valid", 256'(ex_valid), 256'(1));

    // Load-use: lw r8, then add using r8.
    inp = '0;
    inp.rw = 1'b1;
    inp.mr = 1'b1;
    inp.m2r = 1'b1;
    inp.rs = 5'd1;
    inp.rt = 5'd8;
    step();
    inp = '0;
    inp.rw = 1'b1;
    inp.rs = 5'd8;
    inp.rt = 5'd9;
    inp.rdd = 5'd10;
    comb_chk();
    chk("lu_hazard", 256'(hazard_stall), 256'(1));
    chk("lu_pc_write", 256'(pc_write), 256'(0));
    chk("lu_if_id", 256'(if_id_write), 256'(0));
    edge_upd();
    chk("lu_bub_valid", 256'(ex_valid), 256'(0));
    chk("lu_bub_rw", 256'(ex_reg_write), 256'(0));
    comb_chk();
    chk("lu_rep_hazard", 256'(hazard_stall), 256'(0));
    edge_upd();
    chk("lu_add_rs", 256'(ex_rs), 256'(5'd8));
    chk("lu_add_valid", 256'(ex_valid), 256'(1));

    // Load targeting r0 never stalls.
    inp = '0;
    inp.mr = 1'b1;
    inp.rt = 5'd0;
    step();
    inp = '0;
    inp.rs = 5'd0;
    comb_chk();
    chk("r0_hazard", 256'(hazard_stall), 256'(0));
    edge_upd();
    chk("r0_valid", 256'(ex_valid), 256'(1));

    // Flush beats load-use.
    inp = '0;
    inp.mr = 1'b1;
    inp.rt = 5'd8;
    step();
    inp = '0;
    inp.rs = 5'd8;
    flush = 1'b1;
    comb_chk();
    chk("fl_hazard", 256'(hazard_stall), 256'(0));
    chk("fl_pc_write", 256'(pc_write), 256'(1));
    edge_upd();
    chk("fl_valid", 256'(ex_valid), 256'(0));
    flush = 1'b0;

    // Freeze for three cycles while ID changes.
    rand_inp();
    step();
    snap = m;
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inp();
      flush = 1'(i == 1);
      comb_chk();
      chk("st_pc_write", 256'(pc_write), 256'(0));
      edge_upd();
      chk("st_hold", 256'(obs), 256'(snap));
    end
    ext_stall = 1'b0;
    flush = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rand_inp();
      reset_n   = ($urandom_range(0, 39) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
